mem_port_arbiter: RTL and testbench

- Shares the single-port unified memory between the instruction-fetch path and the load/store data path of the multicycle CPU.
- Each requester issues a request and holds it until it sees a one-cycle ack.
- The arbiter grants one requester at a time, sequences a fixed-latency memory access, returns read data and flags bad addresses.
- It sits between the FSM-driven datapath (PC register / ALU result / rt operand) and the memory.

---
 rtl/mem_port_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-port memory between the
// instruction-fetch port and the load/store data port of a multicycle CPU.
module mem_port_arbiter #(
    parameter int LATENCY = 1,
    parameter int ADDR_W  = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    output logic              if_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_ack,
    output logic [31:0]       d_rdata,
    output logic              d_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state_q, state_d;
    logic              last_grant_q, last_grant_d;   // 1 = data port
    logic              grant_q, grant_d;             // 1 = data port
    logic              err_q, err_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              if_ack_q, if_ack_d, if_err_q, if_err_d;
    logic              d_ack_q, d_ack_d, d_err_q, d_err_d;
    logic [31:0]       if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic              mem_en_q, mem_en_d, mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              busy_q, busy_d;

    logic              sel_d;
    logic              sel_we;
    logic              sel_err;
    logic [31:0]       sel_addr;

    // On contention the port that did not win last time gets the grant.
    always_comb begin
        sel_d    = d_req && (!if_req || !last_grant_q);
        sel_addr = sel_d ? d_addr : if_addr;
        sel_we   = sel_d && d_we;
        sel_err  = (sel_addr[1:0] != 2'b00) || ((sel_addr >> (ADDR_W + 2)) != 32'd0);
    end

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        err_d        = err_q;
        cnt_d        = cnt_q;
        if_ack_d     = 1'b0;
        if_err_d     = 1'b0;
        d_ack_d      = 1'b0;
        d_err_d      = 1'b0;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        mem_en_d     = mem_en_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    grant_d      = sel_d;
                    last_grant_d = sel_d;
                    err_d        = sel_err;
                    if (sel_err) begin
                        state_d  = RESP;
                        if_ack_d = !sel_d;
                        d_ack_d  = sel_d;
                        if_err_d = !sel_d;
                        d_err_d  = sel_d;
                    end else begin
                        state_d    = ACCESS;
                        cnt_d      = 4'(LATENCY - 1);
                        mem_en_d   = 1'b1;
                        mem_we_d   = sel_we;
                        mem_addr_d = sel_addr[ADDR_W+1:2];
                        if (sel_we) begin
                            mem_wdata_d = d_wdata;
                        end
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == 4'd0) begin
                    if (!mem_we_q) begin
                        if (grant_q) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            if_rdata_d = mem_rdata;
                        end
                    end
                    state_d  = RESP;
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    if_ack_d = !grant_q;
                    d_ack_d  = grant_q;
                    if_err_d = !grant_q && err_q;
                    d_err_d  = grant_q && err_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            err_q        <= 1'b0;
            cnt_q        <= 4'd0;
            if_ack_q     <= 1'b0;
            if_err_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            d_err_q      <= 1'b0;
            if_rdata_q   <= 32'd0;
            d_rdata_q    <= 32'd0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'd0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            err_q        <= err_d;
            cnt_q        <= cnt_d;
            if_ack_q     <= if_ack_d;
            if_err_q     <= if_err_d;
            d_ack_q      <= d_ack_d;
            d_err_q      <= d_err_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign if_err    = if_err_q;
    assign if_rdata  = if_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_err     = d_err_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: three instances (LATENCY 1, 3, 4),
// each with its own fixed-latency memory model.
module tb_mem_port_arbiter;

    localparam int NI = 3;

    logic        clk = 1'b0;
    logic        reset     [NI];
    logic        if_req    [NI];
    logic [31:0] if_addr   [NI];
    logic        if_ack    [NI];
    logic [31:0] if_rdata  [NI];
    logic        if_err    [NI];
    logic        d_req     [NI];
    logic        d_we      [NI];
    logic [31:0] d_addr    [NI];
    logic [31:0] d_wdata   [NI];
    logic        d_ack     [NI];
    logic [31:0] d_rdata   [NI];
    logic        d_err     [NI];
    logic        mem_en    [NI];
    logic        mem_we    [NI];
    logic [9:0]  mem_addr  [NI];
    logic [31:0] mem_wdata [NI];
    logic [31:0] mem_rdata [NI];
    logic        busy      [NI];

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        if (i == 1) return 32'h2008_0005;
        return 32'hC0DE_0000 | 32'(i);
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
        logic [31:0] mem [1024];
        int          en_cnt = 0;

        initial begin
            for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
        end

        // Read data is garbage until enable has been held LAT cycles.
        always @(posedge clk) begin
            if (mem_en[g]) begin
                en_cnt <= en_cnt + 1;
                if (mem_we[g]) mem[mem_addr[g]] = mem_wdata[g];
            end else begin
                en_cnt <= 0;
            end
        end
        assign mem_rdata[g] = (mem_en[g] && en_cnt >= LAT - 1) ? mem[mem_addr[g]] : 32'hBAD0_BAD0;

        mem_port_arbiter #(.LATENCY(LAT), .ADDR_W(10)) u_dut (
            .clk       (clk),
            .reset     (reset[g]),
            .if_req    (if_req[g]),
            .if_addr   (if_addr[g]),
            .if_ack    (if_ack[g]),
            .if_rdata  (if_rdata[g]),
            .if_err    (if_err[g]),
            .d_req     (d_req[g]),
            .d_we      (d_we[g]),
            .d_addr    (d_addr[g]),
            .d_wdata   (d_wdata[g]),
            .d_ack     (d_ack[g]),
            .d_rdata   (d_rdata[g]),
            .d_err     (d_err[g]),
            .mem_en    (mem_en[g]),
            .mem_we    (mem_we[g]),
            .mem_addr  (mem_addr[g]),
            .mem_wdata (mem_wdata[g]),
            .mem_rdata (mem_rdata[g]),
            .busy      (busy[g])
        );
    end

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
        bit          err;
        int          lat;
        bit          drop;
    } sb_t;

    sb_t         sb[$];
    logic [31:0] ref_mem [NI][1024];
    logic [31:0] exp_if_rdata [NI];
    logic [31:0] exp_d_rdata  [NI];
    int          n_chk = 0;
    int          n_err = 0;
    int          en_cyc, we_cyc;
    logic [31:0] last_maddr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input int k);
        @(negedge clk);
        reset[k] = 1'b1;
        @(negedge clk);
        reset[k] = 1'b0;
        exp_if_rdata[k] = 32'd0;
        exp_d_rdata[k]  = 32'd0;
    endtask

    // Drive a request and push the response the bench predicts for it.
    task automatic issue(input int k, input bit is_d, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input int lat, input bit drop);
        sb_t e;
        bit  err;
        err = (addr[1:0] != 2'b00) || ((addr >> 12) != 32'd0);
        if (!err) begin
            if (is_d && we)  ref_mem[k][addr[11:2]] = wdata;
            else if (is_d)   exp_d_rdata[k]  = ref_mem[k][addr[11:2]];
            else             exp_if_rdata[k] = ref_mem[k][addr[11:2]];
        end
        e.is_d  = is_d;
        e.err   = err;
        e.rdata = is_d ? exp_d_rdata[k] : exp_if_rdata[k];
        e.lat   = lat;
        e.drop  = drop;
        sb.push_back(e);
        if (is_d) begin
            d_req[k] = 1'b1; d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wdata;
        end else begin
            if_req[k] = 1'b1; if_addr[k] = addr;
        end
    endtask

    // Collect n acks, comparing each against the scoreboard head, then idle one cycle.
    task automatic wait_acks(input int k, input int n, output int en_c, output int we_c,
                             output logic [31:0] maddr);
        int  cyc;
        int  got;
        sb_t e;
        cyc = 0; got = 0; en_c = 0; we_c = 0; maddr = 32'd0;
        while (got < n && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (mem_en[k]) begin
                en_c++;
                maddr = 32'(mem_addr[k]);
            end
            if (mem_we[k]) we_c++;
            if (if_ack[k] || d_ack[k]) begin
                got++;
                if (sb.size() == 0) begin
                    check("unexpected_ack", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("ack_err_flags", 32'({if_ack[k], d_ack[k], if_err[k], d_err[k]}),
                          e.is_d ? 32'({3'b010, e.err}) : 32'({2'b10, e.err, 1'b0}));
                    check(e.is_d ? "d_rdata" : "if_rdata", e.is_d ? d_rdata[k] : if_rdata[k], e.rdata);
                    check("ack_cycle", 32'(cyc), 32'(e.lat));
                    if (e.drop) begin
                        if (e.is_d) d_req[k] = 1'b0;
                        else        if_req[k] = 1'b0;
                    end
                end
            end
        end
        if (got < n) check("ack_timeout", 32'(got), 32'(n));
        @(negedge clk);
        check("idle_after_resp", 32'({busy[k], if_ack[k], d_ack[k], mem_en[k]}), 32'd0);
    endtask

    initial begin
        for (int k = 0; k < NI; k++) begin
            reset[k] = 1'b1; if_req[k] = 1'b0; if_addr[k] = 32'd0;
            d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = 32'd0; d_wdata[k] = 32'd0;
            exp_if_rdata[k] = 32'd0; exp_d_rdata[k] = 32'd0;
            for (int i = 0; i < 1024; i++) ref_mem[k][i] = init_word(i);
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            check("rst_ctl", 32'({if_ack[k], d_ack[k], if_err[k], d_err[k], mem_en[k], mem_we[k], busy[k]}), 32'd0);
            check("rst_if_rdata", if_rdata[k], 32'd0);
            check("rst_d_rdata", d_rdata[k], 32'd0);
            check("rst_mem_addr", 32'(mem_addr[k]), 32'd0);
            check("rst_mem_wdata", mem_wdata[k], 32'd0);
            reset[k] = 1'b0;
        end

        // Single fetch, LATENCY=1.
        issue(0, 1'b0, 1'b0, 32'h0000_0004, 32'd0, 2, 1'b1);
        wait_acks(0, 1, en_cyc, we_cyc, last_maddr);
        check("fetch_en_cycles", 32'(en_cyc), 32'd1);
        check("fetch_mem_addr", last_maddr, 32'd1);

        // Store then load the same word.
        issue(0, 1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 2, 1'b1);
        wait_acks(0, 1, en_cyc, we_cyc, last_maddr);
        check("store_we_cycles", 32'(we_cyc), 32'd1);
        check("store_mem_addr", last_maddr, 32'd4);
        issue(0, 1'b1, 1'b0, 32'h0000_0010, 32'd0, 2, 1'b1);
        wait_acks(0, 1, en_cyc, we_cyc, last_maddr);
        check("load_we_cycles", 32'(we_cyc), 32'd0);

        // Contention straight from reset: fetch wins first.
        do_reset(0);
        issue(0, 1'b0, 1'b0, 32'h0000_0008, 32'd0, 2, 1'b1);
        issue(0, 1'b1, 1'b0, 32'h0000_0004, 32'd0, 5, 1'b1);
        wait_acks(0, 2, en_cyc, we_cyc, last_maddr);

        // Both held: grants alternate IF, D, IF, D.
        issue(0, 1'b0, 1'b0, 32'h0000_000C, 32'd0, 2, 1'b0);
        issue(0, 1'b1, 1'b0, 32'h0000_0014, 32'd0, 5, 1'b0);
        issue(0, 1'b0, 1'b0, 32'h0000_000C, 32'd0, 8, 1'b1);
        issue(0, 1'b1, 1'b0, 32'h0000_0014, 32'd0, 11, 1'b1);
        wait_acks(0, 4, en_cyc, we_cyc, last_maddr);
        check("alt_en_cycles", 32'(en_cyc), 32'd4);

        // Error responses: misaligned data, out-of-range fetch.
        issue(0, 1'b1, 1'b0, 32'h0000_0013, 32'd0, 1, 1'b1);
        wait_acks(0, 1, en_cyc, we_cyc, last_maddr);
        check("d_err_no_mem", 32'(en_cyc), 32'd0);
        issue(0, 1'b0, 1'b0, 32'h0000_1000, 32'd0, 1, 1'b1);
        wait_acks(0, 1, en_cyc, we_cyc, last_maddr);
        check("if_err_no_mem", 32'(en_cyc), 32'd0);

        // LATENCY=3 fetch.
        issue(1, 1'b0, 1'b0, 32'h0000_0008, 32'd0, 4, 1'b1);
        wait_acks(1, 1, en_cyc, we_cyc, last_maddr);
        check("lat3_en_cycles", 32'(en_cyc), 32'd3);
        check("lat3_mem_addr", last_maddr, 32'd2);

        // LATENCY=4: reset in 2nd ACCESS cycle, request still high during reset.
        @(negedge clk);
        if_req[2] = 1'b1; if_addr[2] = 32'h0000_0008;
        @(negedge clk);
        check("abort_access1", 32'({mem_en[2], busy[2]}), 32'b11);
        @(negedge clk);
        reset[2] = 1'b1;
        @(negedge clk);
        check("abort_idle", 32'({busy[2], mem_en[2], mem_we[2], if_ack[2], d_ack[2]}), 32'd0);
        reset[2] = 1'b0;
        if_req[2] = 1'b0;
        exp_if_rdata[2] = 32'd0;
        exp_d_rdata[2]  = 32'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_ack", 32'({busy[2], if_ack[2], d_ack[2]}), 32'd0);
        end
        issue(2, 1'b0, 1'b0, 32'h0000_0008, 32'd0, 5, 1'b1);
        wait_acks(2, 1, en_cyc, we_cyc, last_maddr);
        check("reissue_en_cycles", 32'(en_cyc), 32'd4);

        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
